count_clusters_param: RTL and testbench
=======================================

Name: count_clusters_param

Overview:
- Parametrised, pipelined popcount of VPF (valid-pattern-flag) bits.
- Successor to the fixed 768-bit cluster counter: generic input width and group size, runtime overflow threshold, valid tracking through the pipe.
- Adds a peak-hold register and a saturating overflow-event counter for trigger/monitoring logic.
- Sits between the cluster-finding VPF outputs and the cluster packer's overflow/readout control, on clock4x.

Parameters:
- NBITS, 1536: number of VPF input bits; any value ≥ 1.
- GROUP, 6: bits per first-stage LUT count; fixed at 6 in this generation; must stay 6.
- CW, $clog2(NBITS+1): count width; derived, not overridable.
- OVF_CNT_W, 16: width of the overflow event counter.

Ports:
- clock4x  in  1  logic clock.
- reset_n  in  1  asynchronous, active-low reset.
- vpfs_i  in  NBITS  VPF bits, one sample per cycle.
- valid_i  in  1  vpfs_i qualifier.
- thresh_i  in  CW  overflow threshold; quasi-static; sampled at the output stage.
- stat_clr_i  in  1  synchronous clear of max_cnt_o and ovf_cnt_o.
- cnt_o  out  CW  popcount of a sample.
- valid_o  out  1  cnt_o/overflow_o qualifier.
- overflow_o  out  1  cnt_o > thresh_i.
- max_cnt_o  out  CW  peak of valid counts since the last clear.
- ovf_cnt_o  out  OVF_CNT_W  number of valid overflow samples; saturating.

Behaviour:
- Reset (async assert, sync release inside the clock domain): all outputs, the valid pipe and all count stages go to 0.
- Input stage:
  - Two register stages on vpfs_i and valid_i.
  - Registers are marked against equivalent-register removal.
- Stage 1:
  - Zero-pad vpfs to NG = ceil(NBITS/6)*6 bits.
  - Per 6-bit group, 3-bit count via single-level LUT logic (bit0 = parity); result registered.
- Adder tree:
  - Pairwise, one register level per layer, LV = clog2(NG/6) levels.
  - Each layer's width is just enough for its maximum count.
  - Odd element at a layer passes through with a zero partner.
- Output stage: registers cnt_o, valid_o, overflow_o together.
- Latency: fixed LAT = 2 + 1 + LV + 1 cycles from valid_i to valid_o.
  - NBITS=768: LV=7, LAT=11.
  - NBITS=1536: LV=8, LAT=12.
- Valid pipe: valid_o is high exactly LAT cycles after valid_i, one-for-one, with no merging.
  - The data path always computes.
  - When valid_o=0: cnt_o holds the computed value and overflow_o is forced 0.
- Arithmetic: unsigned. Maximum count NBITS never wraps, because CW fits NBITS.
- overflow_o: strict greater-than. cnt == thresh_i gives 0. thresh_i = 0 flags any nonzero count.
- Peak hold, on a cycle with valid_o=1 at the output stage:
  - max_cnt_o updates to the max of itself and cnt.
  - Updates one cycle after cnt_o, from the same registered value.
- Overflow counter: increments by 1 per valid overflow sample and saturates at all-ones; never wraps.
- stat_clr_i (synchronous), same cycle as an update:
  - max_cnt_o loads the current count if valid, else 0.
  - ovf_cnt_o loads 1 if a valid overflow is present, else 0.
  - So clear never drops a sample.
- Reset mid-operation: in-flight samples are discarded. No spurious valid_o appears after reset release; the first valid_o comes LAT cycles after the first post-reset valid_i.
- Back-to-back valid samples every cycle are fully supported. There is no back-pressure.

Decomposition:
- Shared package cluster_count_pkg holds:
  - The fast6count function.
  - A clog2 helper.
  - Constant GROUP6 = 6.
- One sub-module, popcount_tree:
  - Parametrised adder tree with layer-width generation.
  - Reused by future per-partition counters.
- The top level holds the input/valid pipe, output stage and statistics.

Test Plan:
- NBITS=768, all-zero then all-ones vpfs with valid_i pulses → valid_o at +11 cycles; cnt_o = 0 then 768; overflow_o 0 then 1 (thresh=8).
- Threshold boundary, thresh_i=8: exactly 8 bits set → overflow_o=0; 9 bits set → overflow_o=1; ovf_cnt_o = 1.
- Odd/pad width, NBITS=1000, all ones → cnt_o = 1000 (padding contributes 0); every single-bit position walked → cnt_o = 1.
- Valid bubbles: pattern 1,0,1,1,0 on valid_i with distinct counts → identical valid_o pattern delayed LAT; counts matched in order; overflow_o=0 on bubbles.
- Reset: assert reset_n=0 with 5 samples in flight → all outputs 0 immediately; zero valid_o pulses after release until new input.
- Statistics: OVF_CNT_W=4, 20 overflow samples → ovf_cnt_o = 15 held. stat_clr_i coincident with a valid count of 37 → max_cnt_o = 37 and ovf_cnt_o = 1.

Source files
------------

// File: rtl/cluster_count_pkg.sv
// Shared constants and helpers for the VPF cluster counters.
package cluster_count_pkg;

    localparam int GROUP6 = 6;

    // Elaboration-time ceil(log2(n)); clog2(1) = 0.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < n) r = i + 1;
        return r;
    endfunction

    // Six-input popcount: every result bit depends on all six inputs, so each
    // maps onto one 6-input LUT; bit0 is simply the parity.
    function automatic logic [2:0] fast6count(input logic [5:0] b);
        logic [2:0] c;
        c = 3'd0;
        for (int i = 0; i < 6; i++)
            c = c + {2'b00, b[i]};
        return c;
    endfunction

endpackage

// File: rtl/popcount_tree.sv
// Pipelined pairwise adder tree over N leaf counts, one register level per layer,
// each layer only as wide as its largest reachable sum.
module popcount_tree
    import cluster_count_pkg::*;
#(
    parameter  int N        = 2,
    parameter  int LEAF_MAX = GROUP6,
    localparam int LEAF_W   = clog2(LEAF_MAX + 1),
    localparam int LV       = clog2(N),
    localparam int OUT_W    = clog2(N * LEAF_MAX + 1)
) (
    input  logic                clock4x,
    input  logic                reset_n,
    input  logic [N*LEAF_W-1:0] leaves,
    output logic [OUT_W-1:0]    sum
);

    function automatic int layer_nodes(input int l);
        return (N + (1 << l) - 1) >> l;
    endfunction

    function automatic int layer_width(input int l);
        int m;
        m = LEAF_MAX << l;
        if (m > N * LEAF_MAX) m = N * LEAF_MAX;
        return clog2(m + 1);
    endfunction

    for (genvar l = 0; l <= LV; l++) begin : lvl
        localparam int NC = layer_nodes(l);
        localparam int W  = layer_width(l);
        logic [W-1:0] node [NC];

        if (l == 0) begin : g_leaf
            for (genvar i = 0; i < NC; i++) begin : g_n
                assign node[i] = leaves[LEAF_W*i +: LEAF_W];
            end
        end else begin : g_add
            localparam int PNC = layer_nodes(l - 1);
            for (genvar i = 0; i < NC; i++) begin : g_n
                if (2*i + 1 < PNC) begin : g_pair
                    // NOTE: count stages are reset as well as the valid pipe, so cnt_o reads 0 right after reset.
                    always_ff @(posedge clock4x or negedge reset_n)
                        if (!reset_n) node[i] <= '0;
                        else          node[i] <= W'(lvl[l-1].node[2*i]) + W'(lvl[l-1].node[2*i+1]);
                end else begin : g_pass
                    // Odd element out: passes through with an implicit zero partner.
                    always_ff @(posedge clock4x or negedge reset_n)
                        if (!reset_n) node[i] <= '0;
                        else          node[i] <= W'(lvl[l-1].node[2*i]);
                end
            end
        end
    end

    assign sum = lvl[LV].node[0];

endmodule

// File: rtl/count_clusters_param.sv
// Pipelined VPF popcount with threshold flag, peak hold and saturating overflow counter.
// Latency from valid_i to valid_o is 2 + 1 + clog2(ceil(NBITS/6)) + 1 cycles.
module count_clusters_param
    import cluster_count_pkg::*;
#(
    parameter  int NBITS     = 1536,
    parameter  int GROUP     = 6,
    parameter  int OVF_CNT_W = 16,
    localparam int CW        = clog2(NBITS + 1)
) (
    input  logic                 clock4x,
    input  logic                 reset_n,
    input  logic [NBITS-1:0]     vpfs_i,
    input  logic                 valid_i,
    input  logic [CW-1:0]        thresh_i,
    input  logic                 stat_clr_i,
    output logic [CW-1:0]        cnt_o,
    output logic                 valid_o,
    output logic                 overflow_o,
    output logic [CW-1:0]        max_cnt_o,
    output logic [OVF_CNT_W-1:0] ovf_cnt_o
);

    // GROUP must stay equal to GROUP6: the leaf counter is the fixed 6-input LUT.
    localparam int NGRP = (NBITS + GROUP - 1) / GROUP;
    localparam int NG   = NGRP * GROUP6;
    localparam int LV   = clog2(NGRP);
    localparam int TW   = clog2(NG + 1);
    localparam int VPW  = LV + 1;

    // Asynchronous assert, release synchronised to clock4x.
    logic [1:0] rst_sync;
    logic       rst_n;

    always_ff @(posedge clock4x or negedge reset_n)
        if (!reset_n) rst_sync <= '0;
        else          rst_sync <= {rst_sync[0], 1'b1};

    assign rst_n = rst_sync[1];

    (* keep = "true" *) logic [NBITS-1:0] vpfs_q1, vpfs_q2;
    (* keep = "true" *) logic             valid_q1, valid_q2;

    always_ff @(posedge clock4x or negedge rst_n)
        if (!rst_n) begin
            vpfs_q1  <= '0;
            vpfs_q2  <= '0;
            valid_q1 <= 1'b0;
            valid_q2 <= 1'b0;
        end else begin
            vpfs_q1  <= vpfs_i;
            vpfs_q2  <= vpfs_q1;
            valid_q1 <= valid_i;
            valid_q2 <= valid_q1;
        end

    logic [NG-1:0]     vpf_pad;
    logic [3*NGRP-1:0] grp_cnt;

    assign vpf_pad = NG'(vpfs_q2);

    always_ff @(posedge clock4x or negedge rst_n)
        if (!rst_n) grp_cnt <= '0;
        else
            for (int g = 0; g < NGRP; g++)
                grp_cnt[3*g +: 3] <= fast6count(vpf_pad[GROUP6*g +: GROUP6]);

    // vpipe[0] travels with grp_cnt, vpipe[LV] with the tree output.
    logic [LV:0] vpipe;

    always_ff @(posedge clock4x or negedge rst_n)
        if (!rst_n) vpipe <= '0;
        else        vpipe <= VPW'({vpipe, valid_q2});

    logic [TW-1:0] tree_sum;
    logic [CW-1:0] tree_cnt;

    popcount_tree #(
        .N        (NGRP),
        .LEAF_MAX (GROUP6)
    ) u_tree (
        .clock4x (clock4x),
        .reset_n (rst_n),
        .leaves  (grp_cnt),
        .sum     (tree_sum)
    );

    assign tree_cnt = CW'(tree_sum);

    always_ff @(posedge clock4x or negedge rst_n)
        if (!rst_n) begin
            cnt_o      <= '0;
            valid_o    <= 1'b0;
            overflow_o <= 1'b0;
        end else begin
            cnt_o      <= tree_cnt;
            valid_o    <= vpipe[LV];
            overflow_o <= vpipe[LV] && (tree_cnt > thresh_i);
        end

    // Statistics run one cycle behind the output stage; a clear reloads from the
    // sample sitting there so it is never lost.
    always_ff @(posedge clock4x or negedge rst_n)
        if (!rst_n) begin
            max_cnt_o <= '0;
            ovf_cnt_o <= '0;
        end else if (stat_clr_i) begin
            max_cnt_o <= valid_o ? cnt_o : '0;
            ovf_cnt_o <= OVF_CNT_W'(overflow_o);
        end else begin
            if (valid_o && (cnt_o > max_cnt_o))
                max_cnt_o <= cnt_o;
            if (overflow_o && (ovf_cnt_o != '1))
                ovf_cnt_o <= ovf_cnt_o + OVF_CNT_W'(1);
        end

endmodule

// File: tb/tb_count_clusters_param.sv
// Directed bench for count_clusters_param: NBITS=768 (4-bit overflow counter) and NBITS=1000.
module tb_count_clusters_param;

    localparam int NA    = 768;
    localparam int NB    = 1000;
    localparam int LAT_A = 11;
    localparam int LAT_B = 12;
    localparam int NBS   = 1002;

    logic clock4x = 1'b0;
    logic reset_n;
    always #5 clock4x = ~clock4x;

    logic [NA-1:0] a_vpfs;
    logic          a_valid, a_clr, a_vo, a_ovf;
    logic [9:0]    a_thresh, a_cnt, a_max;
    logic [3:0]    a_ovfcnt;

    logic [NB-1:0] b_vpfs;
    logic          b_valid, b_clr, b_vo, b_ovf;
    logic [9:0]    b_thresh, b_cnt, b_max;
    logic [15:0]   b_ovfcnt;

    int n_cmp = 0;
    int n_bad = 0;

    int   bub_cnt [5] = '{3, 50, 5, 700, 100};
    logic bub_val [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic bub_ovf [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    count_clusters_param #(.NBITS(NA), .OVF_CNT_W(4)) dut_a (
        .clock4x    (clock4x),
        .reset_n    (reset_n),
        .vpfs_i     (a_vpfs),
        .valid_i    (a_valid),
        .thresh_i   (a_thresh),
        .stat_clr_i (a_clr),
        .cnt_o      (a_cnt),
        .valid_o    (a_vo),
        .overflow_o (a_ovf),
        .max_cnt_o  (a_max),
        .ovf_cnt_o  (a_ovfcnt)
    );

    count_clusters_param #(.NBITS(NB)) dut_b (
        .clock4x    (clock4x),
        .reset_n    (reset_n),
        .vpfs_i     (b_vpfs),
        .valid_i    (b_valid),
        .thresh_i   (b_thresh),
        .stat_clr_i (b_clr),
        .cnt_o      (b_cnt),
        .valid_o    (b_vo),
        .overflow_o (b_ovf),
        .max_cnt_o  (b_max),
        .ovf_cnt_o  (b_ovfcnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
            $error("comparison %s", tag);
        end
    endtask

    task automatic tick();
        @(posedge clock4x);
        #1;
    endtask

    function automatic logic [NA-1:0] mask_a(input int n);
        logic [NA-1:0] m;
        m = '0;
        for (int i = 0; i < n; i++) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic [NA-1:0] spread_a(input int n, input int stride);
        logic [NA-1:0] m;
        m = '0;
        for (int i = 0; i < n; i++) m[i*stride] = 1'b1;
        return m;
    endfunction

    function automatic logic [NB-1:0] sample_b(input int s);
        logic [NB-1:0] m;
        m = '0;
        if (s == 1) m = '1;
        else if (s >= 2) m[s-2] = 1'b1;
        return m;
    endfunction

    // One valid sample into dut_a; returns right after its result reaches the outputs.
    task automatic run_a(input logic [NA-1:0] v);
        a_vpfs  = v;
        a_valid = 1'b1;
        tick();
        a_vpfs  = '0;
        a_valid = 1'b0;
        repeat (LAT_A - 1) tick();
    endtask

    initial begin
        int pulses;
        int s;
        a_vpfs = '0; a_valid = 1'b0; a_thresh = 10'd8; a_clr = 1'b0;
        b_vpfs = '0; b_valid = 1'b0; b_thresh = 10'd0; b_clr = 1'b0;
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        repeat (3) tick();
        check("reset_a", {a_vo, a_ovf, a_cnt, a_max, a_ovfcnt}, 0);
        check("reset_b", {b_vo, b_ovf, b_cnt, b_max, b_ovfcnt}, 0);
        reset_n = 1'b1;
        repeat (4) tick();

        // All-zero then all-ones, back to back: exact latency of 11.
        a_vpfs = '0; a_valid = 1'b1;
        tick();
        a_vpfs = '1;
        tick();
        a_vpfs = '0; a_valid = 1'b0;
        repeat (8) tick();
        check("lat_early", a_vo, 0);
        tick();
        check("zeros_out", {a_vo, a_ovf, a_cnt}, {1'b1, 1'b0, 10'd0});
        tick();
        check("ones_out", {a_vo, a_ovf, a_cnt}, {1'b1, 1'b1, 10'd768});
        tick();
        check("ones_after", {a_vo, a_ovf}, 0);
        check("ones_stats", {a_max, a_ovfcnt}, {10'd768, 4'd1});

        // Clear with nothing valid at the output loads zeros.
        a_clr = 1'b1;
        tick();
        a_clr = 1'b0;
        check("clr_idle", {a_max, a_ovfcnt}, 0);

        // Threshold boundary at 8: strictly greater-than.
        run_a(spread_a(8, 97));
        check("thr_eq", {a_vo, a_ovf, a_cnt}, {1'b1, 1'b0, 10'd8});
        run_a(spread_a(9, 85));
        check("thr_gt", {a_vo, a_ovf, a_cnt}, {1'b1, 1'b1, 10'd9});
        tick();
        check("thr_stats", {a_max, a_ovfcnt}, {10'd9, 4'd1});

        // Valid bubbles 1,0,1,1,0 with distinct counts.
        for (int i = 0; i < 5; i++) begin
            a_vpfs  = mask_a(bub_cnt[i]);
            a_valid = bub_val[i];
            tick();
        end
        a_vpfs = '0; a_valid = 1'b0;
        repeat (LAT_A - 5) tick();
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bubble%0d", i), {a_vo, a_ovf, a_cnt},
                  {bub_val[i], bub_ovf[i], 10'(bub_cnt[i])});
            tick();
        end
        check("bubble_stats", {a_max, a_ovfcnt}, {10'd700, 4'd2});

        // 20 overflow samples: 4-bit counter saturates at 15.
        a_vpfs = '1; a_valid = 1'b1;
        repeat (20) tick();
        a_vpfs = '0; a_valid = 1'b0;
        repeat (LAT_A + 1) tick();
        check("ovf_sat", {a_max, a_ovfcnt}, {10'd768, 4'd15});

        // Clear coincident with a valid count of 37.
        run_a(mask_a(37));
        check("cnt37", {a_vo, a_ovf, a_cnt}, {1'b1, 1'b1, 10'd37});
        a_clr = 1'b1;
        tick();
        a_clr = 1'b0;
        check("clr_valid", {a_max, a_ovfcnt}, {10'd37, 4'd1});

        // Reset with the pipe full.
        a_vpfs = '1; a_valid = 1'b1;
        repeat (LAT_A + 2) tick();
        check("pre_reset", {a_vo, a_cnt}, {1'b1, 10'd768});
        reset_n = 1'b0;
        #1;
        check("mid_reset_a", {a_vo, a_ovf, a_cnt, a_max, a_ovfcnt}, 0);
        a_vpfs = '0; a_valid = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < LAT_A + 4; i++) begin
            tick();
            pulses += int'(a_vo);
        end
        check("no_spurious", pulses, 0);
        run_a(mask_a(5));
        check("post_reset", {a_vo, a_ovf, a_cnt}, {1'b1, 1'b0, 10'd5});

        // NBITS=1000 stream, thresh 0: zeros, all ones, then every single-bit position.
        for (int c = 0; c < NBS + LAT_B - 1; c++) begin
            b_vpfs  = sample_b(c);
            b_valid = (c < NBS);
            tick();
            s = c + 1 - LAT_B;
            if (s == 0)
                check("b_zeros", {b_vo, b_ovf, b_cnt}, {1'b1, 1'b0, 10'd0});
            else if (s == 1)
                check("b_ones", {b_vo, b_ovf, b_cnt}, {1'b1, 1'b1, 10'd1000});
            else if (s >= 2)
                check($sformatf("b_walk%0d", s - 2), {b_vo, b_ovf, b_cnt}, {1'b1, 1'b1, 10'd1});
        end
        b_valid = 1'b0;
        tick();
        check("b_stats", {b_max, b_ovfcnt}, {10'd1000, 16'd1001});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
